// File: rtl/my_serdes_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : my_serdes_rx_pkg
// Brief   : SERDES link constants, lock state encoding and rx word layout.
// Revision: 1.0 - initial release
// ============================================================================
package my_serdes_rx_pkg;

  localparam logic [15:0] SERDES_COMMA_DAT = 16'h3C3C;
  localparam logic [1:0]  SERDES_COMMA_K   = 2'b11;
  localparam int unsigned RX_WORD_W        = 18;

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  typedef struct packed {
    logic        kmsb;
    logic        klsb;
    logic [15:0] dat;
  } rx_word_t;

  // Only the exact idle pattern is a comma; any other K combination is payload.
  function automatic logic is_comma(input rx_word_t w);
    return ({w.kmsb, w.klsb} == SERDES_COMMA_K) && (w.dat == SERDES_COMMA_DAT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/my_serdes_rx_if.sv
`default_nettype none
// ============================================================================
// Module  : my_serdes_rx_if
// Brief   : SERDES rx word in, buffered DSP deq port and link status out.
// Revision: 1.0 - initial release
// ============================================================================
interface my_serdes_rx_if;

  logic [15:0] ser_r;
  logic        ser_rklsb;
  logic        ser_rkmsb;
  logic [15:0] rx_dat_o;
  logic        rx_klsb_o;
  logic        rx_kmsb_o;
  logic        rx_rdy;
  logic        rx_en;
  logic        link_up;
  logic        rx_overflow;

  modport slave (
    input  ser_r, ser_rklsb, ser_rkmsb, rx_en,
    output rx_dat_o, rx_klsb_o, rx_kmsb_o, rx_rdy, link_up, rx_overflow
  );

  modport master (
    output ser_r, ser_rklsb, ser_rkmsb, rx_en,
    input  rx_dat_o, rx_klsb_o, rx_kmsb_o, rx_rdy, link_up, rx_overflow
  );

endinterface
`default_nettype wire

// File: rtl/my_serdes_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : my_serdes_rx_fifo
// Brief   : Sized FIFO with guarded enq/deq; full/empty sampled before update.
// Revision: 1.0 - initial release
// ============================================================================
module my_serdes_rx_fifo #(
  parameter int unsigned WIDTH      = 18,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNTR_WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq,
  input  logic             deq,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             not_empty,
  output logic             not_full
);

  localparam logic [CNTR_WIDTH:0]   c_depth = (CNTR_WIDTH + 1)'(DEPTH);
  localparam logic [CNTR_WIDTH-1:0] c_last  = CNTR_WIDTH'(DEPTH - 1);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [CNTR_WIDTH-1:0] r_wr_ptr;
  logic [CNTR_WIDTH-1:0] r_rd_ptr;
  logic [CNTR_WIDTH:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_do_enq;
  logic w_do_deq;

  assign w_full   = (r_count == c_depth);
  assign w_empty  = (r_count == '0);
  // A full FIFO refuses the write even when a read frees a slot this cycle.
  assign w_do_enq = enq && !w_full;
  assign w_do_deq = deq && !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_enq) begin
        r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + CNTR_WIDTH'(1);
      end
      if (w_do_deq) begin
        r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + CNTR_WIDTH'(1);
      end
      case ({w_do_enq, w_do_deq})
        2'b10:   r_count <= r_count + (CNTR_WIDTH + 1)'(1);
        2'b01:   r_count <= r_count - (CNTR_WIDTH + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_enq) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  assign dout      = r_mem[r_rd_ptr];
  assign not_empty = !w_empty;
  assign not_full  = !w_full;

endmodule
`default_nettype wire

// File: rtl/my_serdes_rx.sv
`default_nettype none
// ============================================================================
// Module  : my_serdes_rx
// Brief   : SERDES rx: input register, comma lock FSM, comma strip, rx FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module my_serdes_rx
  import my_serdes_rx_pkg::*;
#(
  parameter int unsigned FIFOSIZE     = 4,
  parameter int unsigned CNTR_WIDTH   = 2,
  parameter int unsigned LOCK_COMMAS  = 4,
  parameter int unsigned LOSS_TIMEOUT = 131071,
  parameter int unsigned TMO_WIDTH    = 17
) (
  input  logic          dsp_clk,
  input  logic          dsp_rst,
  my_serdes_rx_if.slave bus
);

  localparam int unsigned          c_run_w        = $clog2(LOCK_COMMAS + 1);
  localparam logic [c_run_w-1:0]   c_lock_commas  = c_run_w'(LOCK_COMMAS);
  localparam logic [TMO_WIDTH-1:0] c_loss_timeout = TMO_WIDTH'(LOSS_TIMEOUT);

  rx_word_t            r_word;
  lock_state_e         r_state;
  logic                r_link_up;
  logic [c_run_w-1:0]  r_comma_run;
  logic [TMO_WIDTH-1:0] r_silence;
  logic                r_overflow;

  logic                w_comma;
  logic [c_run_w-1:0]  w_comma_run_inc;
  logic [TMO_WIDTH-1:0] w_silence_inc;
  logic                w_enq_req;
  logic                w_fifo_not_empty;
  logic                w_fifo_not_full;
  rx_word_t            w_head;

  always_ff @(posedge dsp_clk) begin
    if (dsp_rst) begin
      r_word <= '0;
    end else begin
      r_word <= {bus.ser_rkmsb, bus.ser_rklsb, bus.ser_r};
    end
  end

  assign w_comma         = is_comma(r_word);
  assign w_comma_run_inc = r_comma_run + c_run_w'(1);
  assign w_silence_inc   = r_silence + TMO_WIDTH'(1);

  // Transitions fire on the edge the counter would reach its limit, so the
  // counters never exceed LOCK_COMMAS-1 / LOSS_TIMEOUT-1 and cannot wrap.
  always_ff @(posedge dsp_clk) begin
    if (dsp_rst) begin
      r_state     <= UNLOCKED;
      r_link_up   <= 1'b0;
      r_comma_run <= '0;
      r_silence   <= '0;
    end else begin
      case (r_state)
        UNLOCKED: begin
          if (!w_comma) begin
            r_comma_run <= '0;
          end else if (w_comma_run_inc == c_lock_commas) begin
            r_state     <= LOCKED;
            r_link_up   <= 1'b1;
            r_comma_run <= '0;
            r_silence   <= '0;
          end else begin
            r_comma_run <= w_comma_run_inc;
          end
        end
        LOCKED: begin
          if (w_comma) begin
            r_silence <= '0;
          end else if (w_silence_inc == c_loss_timeout) begin
            r_state     <= UNLOCKED;
            r_link_up   <= 1'b0;
            r_comma_run <= '0;
            r_silence   <= '0;
          end else begin
            r_silence <= w_silence_inc;
          end
        end
        default: begin
          r_state   <= UNLOCKED;
          r_link_up <= 1'b0;
        end
      endcase
    end
  end

  // Words seen while unlocked are discarded, commas are never buffered.
  assign w_enq_req = (r_state == LOCKED) && !w_comma;

  always_ff @(posedge dsp_clk) begin
    if (dsp_rst) begin
      r_overflow <= 1'b0;
    end else if (w_enq_req && !w_fifo_not_full) begin
      r_overflow <= 1'b1;
    end
  end

  my_serdes_rx_fifo #(
    .WIDTH      (RX_WORD_W),
    .DEPTH      (FIFOSIZE),
    .CNTR_WIDTH (CNTR_WIDTH)
  ) u_fifo (
    .clk       (dsp_clk),
    .rst       (dsp_rst),
    .enq       (w_enq_req),
    .deq       (bus.rx_en),
    .din       (r_word),
    .dout      (w_head),
    .not_empty (w_fifo_not_empty),
    .not_full  (w_fifo_not_full)
  );

  assign bus.rx_dat_o    = w_head.dat;
  assign bus.rx_klsb_o   = w_head.klsb;
  assign bus.rx_kmsb_o   = w_head.kmsb;
  assign bus.rx_rdy      = w_fifo_not_empty;
  assign bus.link_up     = r_link_up;
  assign bus.rx_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_my_serdes_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_my_serdes_rx
// Brief   : Directed vector table plus hand sequences for my_serdes_rx.
// Revision: 1.0 - initial release
// ============================================================================
module tb_my_serdes_rx;
  import my_serdes_rx_pkg::*;

  localparam int          L  = 20;
  localparam logic [15:0] CD = SERDES_COMMA_DAT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  my_serdes_rx_if bus();

  my_serdes_rx #(
    .FIFOSIZE     (4),
    .CNTR_WIDTH   (2),
    .LOCK_COMMAS  (4),
    .LOSS_TIMEOUT (L),
    .TMO_WIDTH    (5)
  ) dut (
    .dsp_clk (clk),
    .dsp_rst (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] dat;
    logic [1:0]  k;
    logic        en;
    logic        x_link;
    logic        x_rdy;
    logic [15:0] x_dat;
    logic [1:0]  x_k;
    logic        x_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] d, input logic [1:0] k, input logic en);
    if (en) begin
      n_checks++;
      if (bus.rx_rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL rx_en_protocol: rx_rdy is %b when deq requested, expected 1", bus.rx_rdy);
      end
    end
    bus.ser_r     = d;
    bus.ser_rkmsb = k[1];
    bus.ser_rklsb = k[0];
    bus.rx_en     = en;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [15:0] d, input logic [1:0] k);
    chk({tag, " rx_rdy"}, bus.rx_rdy, 1);
    chk({tag, " rx_dat_o"}, bus.rx_dat_o, d);
    chk({tag, " rx_k"}, {bus.rx_kmsb_o, bus.rx_klsb_o}, k);
  endtask

  function automatic void add(input logic [15:0] d, input logic [1:0] k, input logic en,
                              input logic xl, input logic xr, input logic [15:0] xd,
                              input logic [1:0] xk, input logic xo);
    vecs.push_back('{d, k, en, xl, xr, xd, xk, xo});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected run to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Unlocked: 3 commas, data, 3 commas, data -> run restarts, nothing stored
    repeat (3) add(CD, 2'b11, 0, 0, 0, 16'h0, 2'b00, 0);
    add(16'hAAAA, 2'b00, 0, 0, 0, 16'h0, 2'b00, 0);
    repeat (3) add(CD, 2'b11, 0, 0, 0, 16'h0, 2'b00, 0);
    add(16'hAAAA, 2'b00, 0, 0, 0, 16'h0, 2'b00, 0);
    // Lock on 4 commas, then first word
    repeat (4) add(CD, 2'b11, 0, 0, 0, 16'h0, 2'b00, 0);
    add(16'h1234, 2'b00, 0, 1, 0, 16'h0,    2'b00, 0);
    add(CD,       2'b11, 0, 1, 1, 16'h1234, 2'b00, 0);
    add(CD,       2'b11, 1, 1, 0, 16'h0,    2'b00, 0);
    // Commas between data words are stripped
    add(16'hD0D0, 2'b00, 0, 1, 0, 16'h0,    2'b00, 0);
    add(CD,       2'b11, 0, 1, 1, 16'hD0D0, 2'b00, 0);
    add(CD,       2'b11, 1, 1, 0, 16'h0,    2'b00, 0);
    add(16'hD1D1, 2'b10, 0, 1, 0, 16'h0,    2'b00, 0);
    add(CD,       2'b11, 0, 1, 1, 16'hD1D1, 2'b10, 0);
    add(CD,       2'b11, 1, 1, 0, 16'h0,    2'b00, 0);
    // Five words into a four-deep FIFO
    add(16'h4000, 2'b00, 0, 1, 0, 16'h0,    2'b00, 0);
    add(16'h4001, 2'b00, 0, 1, 1, 16'h4000, 2'b00, 0);
    add(16'h4002, 2'b00, 0, 1, 1, 16'h4000, 2'b00, 0);
    add(16'h4003, 2'b00, 0, 1, 1, 16'h4000, 2'b00, 0);
    add(16'h4004, 2'b00, 0, 1, 1, 16'h4000, 2'b00, 0);
    add(CD,       2'b11, 0, 1, 1, 16'h4000, 2'b00, 1);
    add(CD,       2'b11, 1, 1, 1, 16'h4001, 2'b00, 1);
    add(CD,       2'b11, 1, 1, 1, 16'h4002, 2'b00, 1);
    add(CD,       2'b11, 1, 1, 1, 16'h4003, 2'b00, 1);
    add(CD,       2'b11, 1, 1, 0, 16'h0,    2'b00, 1);

    drive(16'h0, 2'b00, 0);
    rst = 1'b1;
    step();
    step();
    chk("reset link_up", bus.link_up, 0);
    chk("reset rx_rdy", bus.rx_rdy, 0);
    chk("reset rx_overflow", bus.rx_overflow, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].dat, vecs[i].k, vecs[i].en);
      step();
      chk($sformatf("v%0d link_up", i), bus.link_up, vecs[i].x_link);
      chk($sformatf("v%0d rx_rdy", i), bus.rx_rdy, vecs[i].x_rdy);
      chk($sformatf("v%0d rx_overflow", i), bus.rx_overflow, vecs[i].x_ovf);
      if (vecs[i].x_rdy) begin
        chk($sformatf("v%0d rx_dat_o", i), bus.rx_dat_o, vecs[i].x_dat);
        chk($sformatf("v%0d rx_k", i), {bus.rx_kmsb_o, bus.rx_klsb_o}, vecs[i].x_k);
      end
    end

    // Lock loss: reset clears overflow, relock, then data only
    rst = 1'b1;
    drive(16'h0, 2'b00, 0);
    step();
    rst = 1'b0;
    chk("A reset rx_overflow", bus.rx_overflow, 0);
    chk("A reset link_up", bus.link_up, 0);
    repeat (5) begin
      drive(CD, 2'b11, 0);
      step();
    end
    chk("A locked link_up", bus.link_up, 1);
    // Last comma registered on the previous edge; link drops L edges later
    for (int j = 0; j < L + 4; j++) begin
      drive(16'h5000 + 16'(j), 2'b00, 0);
      step();
      chk($sformatf("A silence j=%0d link_up", j), bus.link_up, (j < L) ? 1 : 0);
    end
    chk("A rx_overflow", bus.rx_overflow, 1);
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("A drain%0d", i), 16'h5000 + 16'(i), 2'b00);
      drive(16'h5100 + 16'(i), 2'b00, 1);
      step();
    end
    chk("A drained rx_rdy", bus.rx_rdy, 0);
    drive(16'h5200, 2'b00, 0);
    step();
    chk("A unlocked no enq rx_rdy", bus.rx_rdy, 0);
    chk("A unlocked link_up", bus.link_up, 0);

    // Near-comma words keep their K flags; reset drops buffered words
    repeat (4) begin
      drive(CD, 2'b11, 0);
      step();
    end
    drive(16'h1C1C, 2'b11, 0);
    step();
    chk("B relock link_up", bus.link_up, 1);
    drive(16'h3C3C, 2'b01, 0);
    step();
    check_head("B k11 word", 16'h1C1C, 2'b11);
    drive(16'h6666, 2'b00, 0);
    step();
    drive(CD, 2'b11, 0);
    step();
    drive(CD, 2'b11, 1);
    step();
    check_head("B k01 word", 16'h3C3C, 2'b01);
    rst = 1'b1;
    drive(CD, 2'b11, 0);
    step();
    rst = 1'b0;
    chk("B reset rx_rdy", bus.rx_rdy, 0);
    chk("B reset link_up", bus.link_up, 0);
    chk("B reset rx_overflow", bus.rx_overflow, 0);

    // Full FIFO with simultaneous deq still drops the incoming word
    repeat (4) begin
      drive(CD, 2'b11, 0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(16'h7000 + 16'(i), 2'b00, 0);
      step();
    end
    drive(16'h7004, 2'b00, 0);
    step();
    chk("C full rx_overflow", bus.rx_overflow, 0);
    check_head("C full head", 16'h7000, 2'b00);
    drive(CD, 2'b11, 1);
    step();
    chk("C enq+deq rx_overflow", bus.rx_overflow, 1);
    for (int i = 1; i < 4; i++) begin
      check_head($sformatf("C drain%0d", i), 16'h7000 + 16'(i), 2'b00);
      drive(CD, 2'b11, 1);
      step();
    end
    chk("C drained rx_rdy", bus.rx_rdy, 0);
    chk("C link_up", bus.link_up, 1);
    chk("C sticky rx_overflow", bus.rx_overflow, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
